// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART blocks.
//   - rx_state_t : receiver FSM state encoding
//   - BAUD_*     : supported baud rates
//   - SEL_*      : one-hot clk_speed_sel codes
//   - OVERSAMPLE : sample ticks per bit period
//   - baud_decode: clk_speed_sel -> baud rate (unknown codes fall back to 9600)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [31:0] BAUD_9600   = 32'd9600;
  localparam logic [31:0] BAUD_56000  = 32'd56000;
  localparam logic [31:0] BAUD_115200 = 32'd115200;

  localparam logic [3:0] SEL_9600   = 4'b1000;
  localparam logic [3:0] SEL_56000  = 4'b0100;
  localparam logic [3:0] SEL_115200 = 4'b0010;

  localparam int unsigned OVERSAMPLE = 16;

  function automatic logic [31:0] baud_decode(input logic [3:0] sel);
    case (sel)
      SEL_56000:  return BAUD_56000;
      SEL_115200: return BAUD_115200;
      default:    return BAUD_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Consumer-side handshake bundle of the oversampling UART receiver.
//   dat_o        : received byte
//   rdy_o        : dat_o holds an unread byte
//   frame_err_o  : stop bit of the byte in dat_o was low
//   parity_err_o : parity mismatch on the byte in dat_o
//   overrun_o    : sticky, a byte completed while rdy_o was set
//   busy_o       : a frame is in progress
//   rd_i         : consumer read strobe
// master = receiver side, slave = consumer side.
interface uart_rx_os16_if;
  logic [7:0] dat_o;
  logic       rdy_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic       rd_i;

  modport master (
    output dat_o, rdy_o, frame_err_o, parity_err_o, overrun_o, busy_o,
    input  rd_i
  );

  modport slave (
    input  dat_o, rdy_o, frame_err_o, parity_err_o, overrun_o, busy_o,
    output rd_i
  );
endinterface

// File: rtl/uart_os_tick_gen.sv
// Fractional 16x-baud tick generator.
// A 32-bit phase accumulator adds OVERSAMPLE*baud every clk; each time it
// reaches SYS_CLK_RATE it wraps and emits a one-clk tick, so the long-run
// tick rate is exactly 16*baud with at most one clk of jitter.
//   clk, rst : clock, asynchronous active-high reset
//   baud     : current baud rate in Hz
//   clr      : synchronous clear of the phase (realigns ticks to an edge)
//   tick     : registered one-clk strobe at 16x baud
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_RATE = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] baud,
  input  logic        clr,
  output logic        tick
);

  localparam logic [31:0] RATE = 32'(SYS_CLK_RATE);

  logic [31:0] acc_reg;
  logic [31:0] sum;

  assign sum = acc_reg + baud * 32'(OVERSAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else if (clr) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else if (sum >= RATE) begin
      acc_reg <= sum - RATE;
      tick    <= 1'b1;
    end else begin
      acc_reg <= sum;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver (8 data bits, optional parity, 1 stop bit).
// rx is double-synchronised, each bit is the majority of samples 7/8/9 of
// its 16-tick period, and a start edge that votes high is dropped as a glitch.
// Bytes land in a holding register with a ready/read handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   rx            : serial line, idle high
//   clk_speed_sel : one-hot baud select (1000/0100/0010 = 9600/56000/115200)
//   rxif          : consumer handshake (dat/rdy/errors/busy out, rd in)
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_RATE = 50000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic [3:0]     clk_speed_sel,
  uart_rx_os16_if.master rxif
);

  localparam logic ODD_BIT = (PARITY_ODD != 0);

  rx_state_t   state_reg;
  logic        rx_meta_reg, rxs_reg, rxs_prev_reg;
  logic [31:0] baud_reg;
  logic [3:0]  cnt_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic        s7_reg, s8_reg;
  logic        par_mis_reg;
  logic [7:0]  dat_reg;
  logic        rdy_reg, ferr_reg, perr_reg, ovr_reg;

  logic tick, start_edge, resolve, bit_val;

  assign start_edge = (state_reg == IDLE) && rxs_prev_reg && !rxs_reg;
  // Sample 9 is taken live from rxs on the resolving tick.
  assign resolve    = tick && (cnt_reg == 4'd9);
  assign bit_val    = (s7_reg & s8_reg) | (s7_reg & rxs_reg) | (s8_reg & rxs_reg);

  uart_os_tick_gen #(.SYS_CLK_RATE(SYS_CLK_RATE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .baud (baud_reg),
    .clr  (start_edge),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_prev_reg <= 1'b1;
      baud_reg     <= 32'(BAUD_RATE);
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      s7_reg       <= 1'b1;
      s8_reg       <= 1'b1;
      par_mis_reg  <= 1'b0;
      dat_reg      <= '0;
      rdy_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      rx_meta_reg  <= rx;
      rxs_reg      <= rx_meta_reg;
      rxs_prev_reg <= rxs_reg;

      // Baud changes are only accepted between frames.
      if (state_reg == IDLE) baud_reg <= baud_decode(clk_speed_sel);

      if (tick) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (cnt_reg == 4'd7) s7_reg <= rxs_reg;
        if (cnt_reg == 4'd8) s8_reg <= rxs_reg;
      end

      if (rxif.rd_i && rdy_reg) begin
        rdy_reg <= 1'b0;
        ovr_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (resolve) begin
            state_reg <= bit_val ? IDLE : DATA;
            idx_reg   <= '0;
          end
        end
        DATA: begin
          if (resolve) begin
            shift_reg <= {bit_val, shift_reg[7:1]};
            idx_reg   <= idx_reg + 3'd1;
            if (idx_reg == 3'd7) state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (resolve) begin
            par_mis_reg <= ((^shift_reg) ^ ODD_BIT) != bit_val;
            state_reg   <= STOP;
          end
        end
        STOP: begin
          if (resolve) begin
            dat_reg  <= shift_reg;
            ferr_reg <= ~bit_val;
            perr_reg <= (PARITY_EN != 0) ? par_mis_reg : 1'b0;
            rdy_reg  <= 1'b1;
            // A same-clk read already cleared ovr_reg above; delivery wins rdy.
            if (rdy_reg && !rxif.rd_i) ovr_reg <= 1'b1;
            state_reg <= bit_val ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rxs_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rxif.dat_o        = dat_reg;
  assign rxif.rdy_o        = rdy_reg;
  assign rxif.frame_err_o  = ferr_reg;
  assign rxif.parity_err_o = perr_reg;
  assign rxif.overrun_o    = ovr_reg;
  assign rxif.busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: one no-parity receiver (dut0) and one
// even-parity receiver (dut1) on the same clock, reset and baud select.
module tb_uart_rx_os16;
  import uart_pkg::*;

  localparam int BC_115200 = 434;   // 50 MHz / 115200
  localparam int BC_56000  = 893;   // 50 MHz / 56000

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [3:0] sel = SEL_115200;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         t0, lat;

  uart_rx_os16_if ifc0 ();
  uart_rx_os16_if ifc1 ();

  uart_rx_os16 #(.SYS_CLK_RATE(50000000), .BAUD_RATE(9600), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .clk_speed_sel(sel), .rxif(ifc0)
  );

  uart_rx_os16 #(.SYS_CLK_RATE(50000000), .BAUD_RATE(9600), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .clk_speed_sel(sel), .rxif(ifc1)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n line bits LSB first, each held for bc clocks; the line keeps the last bit.
  task automatic drive_bits(input bit which, input logic [10:0] bits, input int n, input int bc);
    for (int i = 0; i < n; i++) begin
      if (which) rx1 = bits[i];
      else       rx0 = bits[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic pulse_rd(input bit which);
    if (which) ifc1.rd_i = 1'b1;
    else       ifc0.rd_i = 1'b1;
    @(negedge clk);
    ifc0.rd_i = 1'b0;
    ifc1.rd_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ifc0.rd_i = 1'b0;
    ifc1.rd_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dat", 32'(ifc0.dat_o), 32'h00);
    chk("rst_rdy", 32'(ifc0.rdy_o), 32'd0);
    chk("rst_busy", 32'(ifc0.busy_o), 32'd0);
    chk("rst_ferr", 32'(ifc0.frame_err_o), 32'd0);
    chk("rst_ovr", 32'(ifc0.overrun_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 at 115200, latency from start edge to rdy_o
    t0 = cyc;
    drive_bits(1'b0, {1'b1, 8'hA5, 1'b0}, 9, BC_115200);
    rx0 = 1'b1;
    while (ifc0.rdy_o !== 1'b1 && (cyc - t0) < 6000) @(negedge clk);
    lat = cyc - t0;
    chk("a5_latency_in_4100_4260", 32'(lat >= 4100 && lat <= 4260), 32'd1);
    repeat (BC_115200) @(negedge clk);
    chk("a5_dat", 32'(ifc0.dat_o), 32'hA5);
    chk("a5_rdy", 32'(ifc0.rdy_o), 32'd1);
    chk("a5_ferr", 32'(ifc0.frame_err_o), 32'd0);
    chk("a5_perr", 32'(ifc0.parity_err_o), 32'd0);
    chk("a5_busy", 32'(ifc0.busy_o), 32'd0);
    pulse_rd(1'b0);
    chk("a5_rd_rdy", 32'(ifc0.rdy_o), 32'd0);
    chk("a5_rd_dat_hold", 32'(ifc0.dat_o), 32'hA5);

    // 25-clk glitch at 9600 baud
    sel = SEL_9600;
    repeat (3) @(negedge clk);
    rx0 = 1'b0;
    repeat (25) @(negedge clk);
    rx0 = 1'b1;
    chk("glitch_busy_on", 32'(ifc0.busy_o), 32'd1);
    repeat (4000) @(negedge clk);
    chk("glitch_busy_off", 32'(ifc0.busy_o), 32'd0);
    chk("glitch_rdy", 32'(ifc0.rdy_o), 32'd0);
    chk("glitch_dat_hold", 32'(ifc0.dat_o), 32'hA5);

    // Overrun: 0x11 then 0x22 without reading
    sel = SEL_115200;
    repeat (3) @(negedge clk);
    drive_bits(1'b0, {1'b1, 8'h11, 1'b0}, 10, BC_115200);
    drive_bits(1'b0, {1'b1, 8'h22, 1'b0}, 10, BC_115200);
    chk("ovr_dat", 32'(ifc0.dat_o), 32'h22);
    chk("ovr_rdy", 32'(ifc0.rdy_o), 32'd1);
    chk("ovr_flag", 32'(ifc0.overrun_o), 32'd1);
    pulse_rd(1'b0);
    chk("ovr_rd_rdy", 32'(ifc0.rdy_o), 32'd0);
    chk("ovr_rd_flag", 32'(ifc0.overrun_o), 32'd0);

    // 0x3C with low stop bit, line held low 20 bit times in total
    drive_bits(1'b0, {1'b0, 8'h3C, 1'b0}, 10, BC_115200);
    repeat (19 * BC_115200) @(negedge clk);
    chk("brk_dat", 32'(ifc0.dat_o), 32'h3C);
    chk("brk_rdy", 32'(ifc0.rdy_o), 32'd1);
    chk("brk_ferr", 32'(ifc0.frame_err_o), 32'd1);
    chk("brk_single_delivery", 32'(ifc0.overrun_o), 32'd0);
    chk("brk_busy", 32'(ifc0.busy_o), 32'd1);
    rx0 = 1'b1;
    repeat (BC_115200) @(negedge clk);
    chk("brk_release_busy", 32'(ifc0.busy_o), 32'd0);
    pulse_rd(1'b0);
    drive_bits(1'b0, {1'b1, 8'h55, 1'b0}, 10, BC_115200);
    chk("post_brk_dat", 32'(ifc0.dat_o), 32'h55);
    chk("post_brk_ferr", 32'(ifc0.frame_err_o), 32'd0);
    chk("post_brk_rdy", 32'(ifc0.rdy_o), 32'd1);
    chk("post_brk_ovr", 32'(ifc0.overrun_o), 32'd0);

    // Even parity on dut1: 0x07 has odd weight, so the correct parity bit is 1
    drive_bits(1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 11, BC_115200);
    chk("par_bad_dat", 32'(ifc1.dat_o), 32'h07);
    chk("par_bad_rdy", 32'(ifc1.rdy_o), 32'd1);
    chk("par_bad_perr", 32'(ifc1.parity_err_o), 32'd1);
    chk("par_bad_ferr", 32'(ifc1.frame_err_o), 32'd0);
    pulse_rd(1'b1);
    drive_bits(1'b1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, BC_115200);
    chk("par_ok_dat", 32'(ifc1.dat_o), 32'h07);
    chk("par_ok_perr", 32'(ifc1.parity_err_o), 32'd0);
    chk("par_ok_ovr", 32'(ifc1.overrun_o), 32'd0);

    // Reset in the middle of data bit 4 at 56000; 0x55 still unread beforehand
    sel = SEL_56000;
    repeat (3) @(negedge clk);
    drive_bits(1'b0, {1'b1, 8'hF0, 1'b0}, 5, BC_56000);
    rx0 = 1'b1;
    repeat (BC_56000 / 2) @(negedge clk);
    chk("mid_busy", 32'(ifc0.busy_o), 32'd1);
    rst = 1'b1;
    #2;
    chk("mid_rst_dat", 32'(ifc0.dat_o), 32'h00);
    chk("mid_rst_rdy", 32'(ifc0.rdy_o), 32'd0);
    chk("mid_rst_busy", 32'(ifc0.busy_o), 32'd0);
    chk("mid_rst_ferr", 32'(ifc0.frame_err_o), 32'd0);
    chk("mid_rst_perr1", 32'(ifc1.parity_err_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BC_56000) @(negedge clk);
    chk("post_rst_idle_rdy", 32'(ifc0.rdy_o), 32'd0);
    drive_bits(1'b0, {1'b1, 8'hC3, 1'b0}, 10, BC_56000);
    chk("c3_dat", 32'(ifc0.dat_o), 32'hC3);
    chk("c3_rdy", 32'(ifc0.rdy_o), 32'd1);
    chk("c3_ferr", 32'(ifc0.frame_err_o), 32'd0);
    chk("c3_ovr", 32'(ifc0.overrun_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
